count_sequencer: RTL and testbench
==================================

# count_sequencer

Command-driven sequencer that owns the 3-bit up/down counter datapath. It accepts a start command with a direction and a target value, then steps the counter once per clock until the target is reached. It signals completion and supports abort and clear. It sits between test or control logic and the counter core, replacing free-running ripple counting with controlled, synchronous runs.

## Interface
- `WIDTH`, default 3: counter width; count range is 0..2^WIDTH-1.
- `CLK`  in  1: clock; all state updates on the rising edge.
- `Reset`  in  1: reset, asynchronous, active-high.
- `Start`  in  1: command strobe; sampled only in IDLE.
- `Dir`  in  1: 1 = count up, 0 = count down; latched with Start.
- `Target`  in  WIDTH: stop value; latched with Start.
- `Abort`  in  1: terminate the run; honoured only in RUN.
- `Clear`  in  1: synchronous zero of Count; honoured only in IDLE.
- `Count`  out  WIDTH: current counter value.
- `Busy`  out  1: high while in RUN.
- `Done`  out  1: one-cycle pulse on normal completion.
- `Aborted`  out  1: one-cycle pulse after an abort.
- `Wrap`  out  1: one-cycle pulse after a modulo wrap step.

## Operation
- Reset values: state = IDLE; Count = 0; Busy = 0; Done = 0; Aborted = 0; Wrap = 0; latched Dir = 1; latched Target = 0.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - Start=1 with Target≠Count: latch Dir and Target, go to RUN. Count is unchanged on this edge.
  - Start=1 with Target==Count: go to DONE (zero-length run). No step occurs.
  - Start=0 and Clear=1: Count←0.
  - Start and Clear in the same cycle: Start wins; Clear is ignored.
  - Abort is ignored.
- RUN:
  - Each edge steps Count ±1, modulo 2^WIDTH.
  - If the stepped value equals the latched Target, go to DONE.
  - Abort=1: go to IDLE with no step on that edge. Count holds. Aborted pulses for the next cycle.
  - Abort takes priority over a step that would reach Target.
  - Start and Clear are ignored.
- DONE: Done=1 for exactly one cycle, then IDLE. Start in DONE is ignored; it is not queued.
- Wrap: registered. High for the cycle after a step from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down).
- Arithmetic: WIDTH-bit unsigned; overflow is discarded.
- Reset asserted mid-run: immediate return to the reset values. No Done or Aborted pulse is produced.

## Timing
- Start sampled at edge k → Busy high from k+1.
- For an N-step run (1 ≤ N ≤ 2^WIDTH-1):
  - Count reaches Target at edge k+N.
  - Busy low and Done high in cycle k+N..k+N+1.
  - IDLE from edge k+N+1.
  - The next Start can be sampled at edge k+N+1 at the earliest.
- Zero-length run: Done high in cycle k..k+1; Busy is never asserted.
- Abort sampled at edge j → Busy low and Aborted high in cycle j..j+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `count_pkg`:
  - state encoding constants: `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2.
  - default `WIDTH` constant.
- Sub-module `count_core`: WIDTH-bit synchronous up/down counter.
  - Inputs: Reset (async, active-high), `en`, `dir`, `clr`.
  - Outputs: `q` and a registered `wrap`.
  - `count_sequencer` instantiates it, so its FSM only generates `en`/`dir`/`clr` and compares `q` to Target.

## Test plan
- Reset released with Count=0; Start, Dir=1, Target=5 → Count 1,2,3,4,5 on consecutive edges; Busy high for 5 cycles; Done pulses once; Wrap never asserts.
- From Count=5: Start, Dir=1, Target=2 → Count 6,7,0,1,2; Wrap pulses once, in the cycle after the 7→0 step; Done after 5 steps.
- From Count=2: Start, Dir=0, Target=6 → Count 1,0,7,6; Wrap pulses after the 0→7 step; Done after 4 steps.
- From Count=3: Start, Target=3 → no step; Done in the next cycle; Busy stays 0.
- Run from 0 up to 7, Abort asserted when Count=3 → Count holds at 3; Aborted pulses once; Done never asserts; a fresh Start is accepted on the following edge.
- Reset asserted while Count=4 in RUN → Count=0 immediately and all outputs 0; Clear with Start=0 in IDLE at Count=6 → Count=0 next edge.

Source files
------------

// File: rtl/count_pkg.sv
// Shared state encoding and default width for the count sequencer slice.
package count_pkg;

    localparam int COUNT_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/count_core.sv
// WIDTH-bit synchronous up/down counter with clear and a registered modulo-wrap flag.
module count_core #(
    parameter int WIDTH = count_pkg::COUNT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d    = dir ? q_q + 1'b1 : q_q - 1'b1;
            // Wrap flags the step that crosses the modulo boundary in either direction.
            wrap_d = dir ? (q_q == {WIDTH{1'b1}}) : (q_q == '0);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/count_sequencer.sv
// Command-driven run controller: steps count_core toward a latched target, with abort and clear.
module count_sequencer
    import count_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Dir,
    input  logic [WIDTH-1:0] Target,
    input  logic             Abort,
    input  logic             Clear,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             Done,
    output logic             Aborted,
    output logic             Wrap
);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             core_en, core_clr;
    logic [WIDTH-1:0] core_q, step_val;

    count_core #(.WIDTH(WIDTH)) u_core (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (core_en),
        .dir   (dir_q),
        .clr   (core_clr),
        .q     (core_q),
        .wrap  (Wrap)
    );

    // Value the counter would take on this edge; compared against target to end the run on time.
    assign step_val = dir_q ? core_q + 1'b1 : core_q - 1'b1;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        target_d  = target_q;
        aborted_d = 1'b0;
        core_en   = 1'b0;
        core_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Target != core_q) begin
                        state_d  = ST_RUN;
                        dir_d    = Dir;
                        target_d = Target;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (Clear) begin
                    core_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (Abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    core_en = 1'b1;
                    if (step_val == target_q) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b1;
            target_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            target_q  <= target_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign Count   = core_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Aborted = aborted_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: runs, wrap, zero-length, abort, clear and async reset.
module tb_count_sequencer;

    logic       CLK = 1'b0;
    logic       Reset, Start, Dir, Abort, Clear;
    logic [2:0] Target;
    logic [2:0] Count;
    logic       Busy, Done, Aborted, Wrap;

    int errors = 0;
    int checks = 0;

    count_sequencer #(.WIDTH(3)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Start   (Start),
        .Dir     (Dir),
        .Target  (Target),
        .Abort   (Abort),
        .Clear   (Clear),
        .Count   (Count),
        .Busy    (Busy),
        .Done    (Done),
        .Aborted (Aborted),
        .Wrap    (Wrap)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] c, input logic b,
                              input logic d, input logic a, input logic w);
        check({tag, ".count"},   8'(Count),   8'(c));
        check({tag, ".busy"},    8'(Busy),    8'(b));
        check({tag, ".done"},    8'(Done),    8'(d));
        check({tag, ".aborted"}, 8'(Aborted), 8'(a));
        check({tag, ".wrap"},    8'(Wrap),    8'(w));
    endtask

    // Issue a Start and follow the run edge by edge against hand-listed count/wrap values.
    task automatic run(input string tag, input logic d, input logic [2:0] tgt,
                       input logic [2:0] from, input int n,
                       input logic [2:0] exp_cnt [8], input logic exp_wrap [8]);
        Start = 1'b1; Dir = d; Target = tgt;
        step();
        Start = 1'b0;
        check_outs({tag, ".accept"}, from, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            step();
            check_outs($sformatf("%s.s%0d", tag, i + 1), exp_cnt[i],
                       (i != n - 1), (i == n - 1), 1'b0, exp_wrap[i]);
        end
        step();
        check_outs({tag, ".idle"}, tgt, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] ec [8];
        logic       ew [8];

        Reset = 1'b1; Start = 1'b0; Dir = 1'b0; Target = 3'd0; Abort = 1'b0; Clear = 1'b0;
        step();
        step();
        check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check_outs("idle_abort_ignored", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        ec = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0};
        ew = '{0, 0, 0, 0, 0, 0, 0, 0};
        run("up0to5", 1'b1, 3'd5, 3'd0, 5, ec, ew);

        ec = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0};
        ew = '{0, 0, 1, 0, 0, 0, 0, 0};
        run("up5to2", 1'b1, 3'd2, 3'd5, 5, ec, ew);

        ec = '{3'd1, 3'd0, 3'd7, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
        ew = '{0, 0, 1, 0, 0, 0, 0, 0};
        run("dn2to6", 1'b0, 3'd6, 3'd2, 4, ec, ew);

        // Clear at 6 returns to zero on the next edge.
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        check_outs("clear", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        ec = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        ew = '{0, 0, 0, 0, 0, 0, 0, 0};
        run("up0to3", 1'b1, 3'd3, 3'd0, 3, ec, ew);

        // Zero-length run, with Clear in the same cycle (Start wins).
        Start = 1'b1; Target = 3'd3; Clear = 1'b1;
        step();
        Clear = 1'b0;
        check_outs("zero_len", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        Target = 3'd5;
        step();
        Start = 1'b0;
        check_outs("start_in_done_ignored", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        Clear = 1'b1;
        step();
        Clear = 1'b0;
        check_outs("clear2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Run toward 7, abort once Count reads 3.
        Start = 1'b1; Dir = 1'b1; Target = 3'd7;
        step();
        Start = 1'b0;
        step(); step(); step();
        check_outs("pre_abort", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check_outs("abort", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        Start = 1'b1; Target = 3'd6;
        step();
        Start = 1'b0;
        check_outs("restart", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_outs("restart_s1", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-run at Count=4.
        #2 Reset = 1'b1;
        #1;
        check_outs("async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        Reset = 1'b0;
        step();
        check_outs("post_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
